seq_mult: RTL and testbench



---
 rtl/seq_mult_pkg.sv | 24 ++
 rtl/seq_mult_booth_step.sv | 38 +++
 rtl/seq_mult.sv | 113 +++++++++++
 tb/tb_seq_mult.sv | 120 ++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package seq_mult_pkg;

  localparam int N_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } booth_op_e;

  // The counter must be able to hold the value N itself.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_mult_booth_step.sv
// One radix-2 Booth iteration: add/sub/pass M into A_hi, then shift
// {A_hi, Q, q_-1} right arithmetically by one.
module booth_step
  import seq_mult_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [N:0]   a_hi_i,
  input  logic [N-1:0] q_i,
  input  logic         q_m1_i,
  input  logic [N:0]   m_i,
  output logic [N:0]   a_hi_o,
  output logic [N-1:0] q_o,
  output logic         q_m1_o
);

  booth_op_e  op;
  logic [N:0] sum;

  always_comb begin
    case ({q_i[0], q_m1_i})
      2'b01:   op = OP_ADD;
      2'b10:   op = OP_SUB;
      default: op = OP_NONE;
    endcase

    case (op)
      OP_ADD:  sum = a_hi_i + m_i;
      OP_SUB:  sum = a_hi_i - m_i;
      default: sum = a_hi_i;
    endcase
  end

  assign a_hi_o = {sum[N], sum[N:1]};
  assign q_o    = {sum[0], q_i[N-1:1]};
  assign q_m1_o = q_i[0];

endmodule

// File: rtl/seq_mult.sv
// Sequential signed N x N -> 2N multiplier, one Booth step per clock.
// Each operation is started by pulsing reset with the operands held stable.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic [2*N-1:0] product
);

  localparam int            CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Reset asserts immediately but releases two edges later, in step with clk.
  logic [1:0] rst_sync_q;
  logic       rst_int;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_sync_q <= 2'b11;
    else       rst_sync_q <= {rst_sync_q[0], 1'b0};
  end

  assign rst_int = rst_sync_q[1];

  state_e         state_q, state_d;
  logic [N:0]     m_q, m_d;
  logic [N:0]     a_hi_q, a_hi_d;
  logic [N-1:0]   q_q, q_d;
  logic           q_m1_q, q_m1_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] product_q, product_d;

  logic [N:0]     step_a_hi;
  logic [N-1:0]   step_q;
  logic           step_q_m1;

  booth_step #(.N(N)) u_booth_step (
    .a_hi_i (a_hi_q),
    .q_i    (q_q),
    .q_m1_i (q_m1_q),
    .m_i    (m_q),
    .a_hi_o (step_a_hi),
    .q_o    (step_q),
    .q_m1_o (step_q_m1)
  );

  // NOTE: every datapath register is reset too, so an aborted operation
  // leaves no stale partial product behind.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state_q   <= IDLE;
      m_q       <= '0;
      a_hi_q    <= '0;
      q_q       <= '0;
      q_m1_q    <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of every other register.
      state_q   <= state_d;
      m_q       <= m_d;
      a_hi_q    <= a_hi_d;
      q_q       <= q_d;
      q_m1_q    <= q_m1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    // NOTE: hold-by-default on every output of this block, so no path
    // through the case leaves a signal unassigned (no latches).
    state_d   = state_q;
    m_d       = m_q;
    a_hi_d    = a_hi_q;
    q_d       = q_q;
    q_m1_d    = q_m1_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        m_d     = {multiplicand[N-1], multiplicand};
        a_hi_d  = '0;
        q_d     = multiplier;
        q_m1_d  = 1'b0;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        a_hi_d = step_a_hi;
        q_d    = step_q;
        q_m1_d = step_q_m1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          product_d = {step_a_hi[N-1:0], step_q};
          state_d   = DONE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign product = product_q;

endmodule

// File: tb/tb_seq_mult.sv
// Directed self-checking bench for seq_mult (N = 32).
`timescale 1ns/1ps
module tb_seq_mult;

  localparam int N   = 32;
  localparam int NOM = N + 2;  // nominal latency in edges
  localparam int MAX = N + 4;  // latency including reset synchronisation

  logic           clk;
  logic           reset;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic [2*N-1:0] product;

  int n_cmp = 0;
  int n_bad = 0;

  seq_mult #(.N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hold reset with the operands applied, then release on a falling edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input int hold);
    reset        = 1'b1;
    multiplicand = a;
    multiplier   = b;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Watch product from release onward; operands are scrambled mid-run.
  task automatic finish_op(input string tag, input logic [63:0] exp, input int extra);
    logic [63:0] early;
    logic [63:0] window;
    logic [63:0] drift;
    early  = '0;
    window = exp;
    drift  = exp;
    for (int k = 1; k <= MAX + extra; k++) begin
      @(posedge clk);
      #1;
      if (k == 6) begin
        multiplicand = ~multiplicand;
        multiplier   = multiplier + 32'd5;
      end
      if (k < NOM) begin
        if (product !== 64'd0 && early === 64'd0) early = product;
      end else if (k < MAX) begin
        if (product !== 64'd0 && product !== exp) window = product;
      end else if (k == MAX) begin
        check({tag, "_result"}, product, exp);
      end else begin
        if (product !== exp && drift === exp) drift = product;
      end
    end
    check({tag, "_zero_before_latency"}, early, 64'd0);
    check({tag, "_latency_window"}, window, exp);
    if (extra > 0) check({tag, "_stable"}, drift, exp);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int hold, input int extra);
    start_op(a, b, hold);
    finish_op(tag, exp, extra);
  endtask

  initial begin
    reset        = 1'b1;
    multiplicand = '0;
    multiplier   = '0;
    #2;
    check("reset_product", product, 64'd0);

    run_op("7x2", 32'd7, 32'd2, 64'd14, 50, 50);

    // Abort from DONE: product must clear without waiting for a clock edge.
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check("async_clear_from_done", product, 64'd0);

    run_op("m7x3",    -32'sd7,  32'sd3,    -64'sd21,  3, 2);
    run_op("m19x3",   -32'sd19, 32'sd3,    -64'sd57,  3, 2);
    run_op("20xm10",  32'sd20,  -32'sd10,  -64'sd200, 3, 2);
    run_op("2xm125",  32'sd2,   -32'sd125, -64'sd250, 3, 2);
    run_op("m2xm2",   -32'sd2,  -32'sd2,   64'sd4,    3, 2);
    run_op("minxmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 3, 20);
    run_op("minx1",   32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, 3, 2);
    run_op("0xm60",   32'sd0,   -32'sd60,  64'd0, 3, 2);
    run_op("m80x0",   -32'sd80, 32'sd0,    64'd0, 3, 2);
    run_op("0x3",     32'd0,    32'd3,     64'd0, 3, 2);
    run_op("5x0",     32'd5,    32'd0,     64'd0, 3, 2);

    // Abort mid-RUN, then restart with new operands.
    start_op(32'd9, 32'd9, 3);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1 check("abort_mid_run", product, 64'd0);
    run_op("3xm4_after_abort", 32'sd3, -32'sd4, -64'sd12, 3, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
